// File: rtl/tri_rr_mux_reg_pkg.sv
// Shared types and helpers for the registered tristate N:1 mux.
// Imported by the interface, arbiter and top.
package tri_mux_pkg;

   typedef enum logic {EMPTY, FULL} state_t;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tri_rr_mux_reg_if.sv
// Channel handshake bundle for tri_rr_mux_reg.
// master drives the channels, slave is the mux side.
interface tri_rr_mux_reg_if #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 2,
   parameter int SEL_W = 1,
   parameter int CNT_W = 16
);
   logic                    en;
   logic [SEL_W-1:0]        sel;
   logic [N_CH-1:0]         in_valid;
   logic [N_CH*WIDTH-1:0]   in_data;
   logic [N_CH-1:0]         in_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        grant_id;
   logic [CNT_W-1:0]        xfer_cnt;

   modport master (
      output en, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, grant_id, xfer_cnt
   );

   modport slave (
      input  en, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, grant_id, xfer_cnt
   );
endinterface

// File: rtl/tri_rr_mux_reg_arb.sv
// Combinational round-robin arbiter: first requester at or
// above ptr, wrapping past N_CH-1 back to 0.
module rr_arbiter #(
   parameter int N_CH  = 2,
   parameter int SEL_W = 1
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en_grant,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx
);
   logic found;
   int   k;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < N_CH; i++) begin
         k = int'(ptr) + i;
         if (k >= N_CH) k = k - N_CH;
         if (!found && req[k]) begin
            found   = 1'b1;
            gnt_idx = SEL_W'(k);
         end
      end
      if (en_grant && found) gnt[gnt_idx] = 1'b1;
   end
endmodule

// File: rtl/tri_rr_mux_reg.sv
// Registered N:1 mux with one-entry output stage driving a
// shared tristate bus; round-robin or fixed channel select.
module tri_rr_mux_reg
   import tri_mux_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int N_CH    = 2,
   parameter int RR_MODE = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   tri_rr_mux_reg_if.slave  bus,
   output wire [WIDTH-1:0]  out_data
);
   localparam int SEL_W = sel_w(N_CH);

   state_t           state, state_n;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] gid_q, rr_ptr, gnt_idx, ptr_n;
   logic [CNT_W-1:0] cnt;
   logic [N_CH-1:0]  gnt;
   logic             drain, load_ok, load, drive;
   logic [WIDTH-1:0] ch [N_CH];

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign ch[c] = bus.in_data[c*WIDTH +: WIDTH];
   end

   assign drain   = (state == FULL) && bus.en && bus.out_ready;
   // Reset masks the grant so no channel sees a phantom accept.
   assign load_ok = !rst && ((state == EMPTY) || drain);
   assign load    = |gnt;

   if (RR_MODE != 0) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^bus.sel;
      rr_arbiter #(
         .N_CH (N_CH),
         .SEL_W(SEL_W)
      ) u_arb (
         .req     (bus.in_valid),
         .ptr     (rr_ptr),
         .en_grant(load_ok),
         .gnt     (gnt),
         .gnt_idx (gnt_idx)
      );
   end else begin : g_fix
      logic unused_ptr;
      assign unused_ptr = ^rr_ptr;
      always_comb begin
         gnt = '0;
         if (load_ok && (int'(bus.sel) < N_CH))
            gnt[bus.sel] = bus.in_valid[bus.sel];
      end
      assign gnt_idx = bus.sel;
   end

   assign ptr_n = (int'(gnt_idx) == N_CH - 1) ? '0
                                                : gnt_idx + 1'b1;

   always_comb begin
      state_n = state;
      unique case (state)
         EMPTY:   if (load)           state_n = FULL;
         FULL:    if (drain && !load) state_n = EMPTY;
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         data_q <= '0;
         gid_q  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            data_q <= ch[gnt_idx];
            gid_q  <= gnt_idx;
            if (RR_MODE != 0) rr_ptr <= ptr_n;
         end
         if (drain && (cnt != '1)) cnt <= cnt + 1'b1;
      end
   end

   assign drive         = bus.en && (state == FULL);
   assign out_data      = drive ? data_q : {WIDTH{1'bz}};
   assign bus.in_ready  = gnt;
   assign bus.out_valid = (state == FULL);
   assign bus.grant_id  = gid_q;
   assign bus.xfer_cnt  = cnt;
endmodule

// File: tb/tb_tri_rr_mux_reg.sv
// Bench for tri_rr_mux_reg: directed steps plus random traffic
// against a transaction-level model of the output stage.
module tb_tri_rr_mux_reg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, rst2;
   int   checks = 0;
   int   errors = 0;

   tri_rr_mux_reg_if #(.WIDTH(8), .N_CH(2), .SEL_W(1), .CNT_W(16)) b0 ();
   tri_rr_mux_reg_if #(.WIDTH(8), .N_CH(2), .SEL_W(1), .CNT_W(4))  b1 ();
   tri_rr_mux_reg_if #(.WIDTH(8), .N_CH(3), .SEL_W(2), .CNT_W(16)) b2 ();
   wire [7:0] d0, d1, d2;

   tri_rr_mux_reg #(.WIDTH(8), .N_CH(2), .RR_MODE(1), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst0), .bus(b0.slave), .out_data(d0));
   tri_rr_mux_reg #(.WIDTH(8), .N_CH(2), .RR_MODE(1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst1), .bus(b1.slave), .out_data(d1));
   tri_rr_mux_reg #(.WIDTH(8), .N_CH(3), .RR_MODE(0), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst2), .bus(b2.slave), .out_data(d2));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Model of u0: a single slot holding one word, a pointer, a count.
   bit         m_full = 1'b0;
   logic [7:0] m_word = '0;
   int         m_gid = 0, m_ptr = 0, m_cnt = 0;

   function automatic int pick();
      for (int i = 0; i < 2; i++)
         if (b0.in_valid[(m_ptr + i) % 2]) return (m_ptr + i) % 2;
      return -1;
   endfunction

   function automatic logic [1:0] exp_rdy();
      logic [1:0] r;
      int g;
      r = '0;
      if (rst0) return r;
      if (m_full && !(b0.en && b0.out_ready)) return r;
      g = pick();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst0) begin
         m_full = 1'b0; m_gid = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         int g;
         bit dr;
         dr = m_full && b0.en && b0.out_ready;
         g  = (!m_full || dr) ? pick() : -1;
         if (dr && m_cnt < 65535) m_cnt++;
         if (g >= 0) begin
            m_word = b0.in_data[g*8 +: 8];
            m_gid  = g;
            m_ptr  = (g + 1) % 2;
            m_full = 1'b1;
         end else if (dr) m_full = 1'b0;
      end
   end

   task automatic chk_main();
      chk("rdy", 32'(b0.in_ready), 32'(exp_rdy()));
      chk("vld", 32'(b0.out_valid), 32'(m_full));
      chk("drv", 32'(u0.drive), 32'(m_full && b0.en));
      if (m_full) chk("gid", 32'(b0.grant_id), m_gid);
      if (m_full && b0.en) chk("data", 32'(d0), 32'(m_word));
      chk("cnt", 32'(b0.xfer_cnt), m_cnt);
   endtask

   task automatic step0(input bit e, input bit r, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b);
      b0.en = e; b0.out_ready = r; b0.in_valid = v; b0.in_data = {b, a};
      #3;
      chk_main();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      b0.en = 1'b1; b0.sel = '0; b0.in_valid = 2'b11;
      b0.in_data = 16'h3CA5; b0.out_ready = 1'b1;
      b1.en = 1'b1; b1.sel = '0; b1.in_valid = 2'b01;
      b1.in_data = 16'h005A; b1.out_ready = 1'b1;
      b2.en = 1'b1; b2.sel = 2'd1; b2.in_valid = 3'b111;
      b2.in_data = 24'h332211; b2.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", 32'(b0.out_valid), 32'd0);
      chk("rst_rdy", 32'(b0.in_ready), 32'd0);
      chk("rst_cnt", 32'(b0.xfer_cnt), 32'd0);
      chk("rst_drv", 32'(u0.drive), 32'd0);
      rst0 = 1'b0;

      step0(1, 1, 2'b11, 8'hA5, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         chk("t2_data", 32'(d0), (i % 2) ? 32'h3C : 32'hA5);
         chk("t2_gid", 32'(b0.grant_id), 32'(i % 2));
         chk("t2_cnt", 32'(b0.xfer_cnt), 32'(i));
         step0(1, 1, 2'b11, 8'hA5, 8'h3C);
      end

      step0(1, 1, 2'b00, 8'h00, 8'h00);
      step0(1, 1, 2'b01, 8'h11, 8'h00);
      c0 = int'(b0.xfer_cnt);
      repeat (3) step0(0, 1, 2'b00, 8'h00, 8'h00);
      chk("t3_vld", 32'(b0.out_valid), 32'd1);
      chk("t3_hold", 32'(b0.xfer_cnt), 32'(c0));
      b0.en = 1'b1;
      #1;
      chk("t3_data", 32'(d0), 32'h11);
      step0(1, 1, 2'b00, 8'h00, 8'h00);
      chk("t3_cnt", 32'(b0.xfer_cnt), 32'(c0 + 1));
      chk("t3_empty", 32'(b0.out_valid), 32'd0);

      step0(1, 1, 2'b01, 8'h55, 8'h00);
      repeat (2) step0(1, 0, 2'b01, 8'h77, 8'h00);
      chk("t4_held", 32'(d0), 32'h55);
      step0(1, 1, 2'b01, 8'h77, 8'h00);
      chk("t4_data", 32'(d0), 32'h77);

      for (int i = 0; i < 400; i++) begin
         rst0 = ($urandom_range(0, 49) == 0);
         step0($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               2'($urandom), 8'($urandom), 8'($urandom));
      end
      rst0 = 1'b0;

      rst1 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("sat8", 32'(b1.xfer_cnt), 32'd8);
      repeat (7) @(posedge clk);
      #1;
      chk("sat15", 32'(b1.xfer_cnt), 32'd15);
      repeat (5) @(posedge clk);
      #1;
      chk("sat_hold", 32'(b1.xfer_cnt), 32'd15);
      chk("sat_vld", 32'(b1.out_valid), 32'd1);
      chk("sat_data", 32'(d1), 32'h5A);
      rst1 = 1'b1;
      #3;
      chk("rst_gate", 32'(b1.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_drop", 32'(b1.out_valid), 32'd0);
      chk("rst_cnt1", 32'(b1.xfer_cnt), 32'd0);

      rst2 = 1'b0;
      #3;
      chk("fx_rdy1", 32'(b2.in_ready), 32'b010);
      @(posedge clk);
      #1;
      chk("fx_gid", 32'(b2.grant_id), 32'd1);
      chk("fx_data", 32'(d2), 32'h22);
      b2.sel = 2'd3;
      #3;
      chk("fx_rdy3", 32'(b2.in_ready), 32'b000);
      @(posedge clk);
      #1;
      chk("fx_empty", 32'(b2.out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("fx_stay", 32'(b2.out_valid), 32'd0);
      b2.sel = 2'd2; b2.in_valid = 3'b011;
      #1;
      chk("fx_novld", 32'(b2.in_ready), 32'b000);
      b2.sel = 2'd0;
      #1;
      chk("fx_rdy0", 32'(b2.in_ready), 32'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
